// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared types and default geometry for the NTT stage
//                scheduler (state encoding, bank/latency defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

    localparam int c_addr_width      = 5;  // 32 words per bank
    localparam int c_bu_late         = 7;  // butterfly pipeline depth
    localparam int c_write_back_late = 2;  // BRAM write settling
    localparam int c_num_stages      = 7;  // butterfly stages per transform
    localparam int c_tw_width        = 7;  // twiddle ROM address width
    localparam int c_stage_width     = 3;  // width of the stage index

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ntt_stage_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_stage_scheduler_if
//  Description : Control/strobe bundle between an NTT controller (master)
//                and the stage scheduler (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ntt_stage_scheduler_if
    import ntt_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int TW_WIDTH   = c_tw_width
);
    logic                     start_i;
    logic                     is_ntt_i;
    logic                     hold_i;
    logic                     rd_en_o;
    logic [ADDR_WIDTH-1:0]    rd_addr_a_o;
    logic [ADDR_WIDTH-1:0]    rd_addr_b_o;
    logic [TW_WIDTH-1:0]      tw_addr_o;
    logic [c_stage_width-1:0] stage_o;
    logic                     wr_en_o;
    logic [ADDR_WIDTH-1:0]    wr_addr_a_o;
    logic [ADDR_WIDTH-1:0]    wr_addr_b_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, is_ntt_i, hold_i,
        input  rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o, busy_o, done_o
    );

    modport slave (
        input  start_i, is_ntt_i, hold_i,
        output rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, stage_o,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/ntt_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_addr_gen
//  Description : Combinational butterfly pair address and twiddle base
//                generator. A zero/one is inserted into the pair index at
//                bit k, where k shrinks as the butterfly span shrinks.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int TW_WIDTH   = c_tw_width
) (
    input  logic [ADDR_WIDTH-2:0]    i_p,
    input  logic [c_stage_width-1:0] i_e,
    output logic [ADDR_WIDTH-1:0]    o_addr_a,
    output logic [ADDR_WIDTH-1:0]    o_addr_b,
    output logic [TW_WIDTH-1:0]      o_tw_addr
);
    // Wide enough to hold p << e before the right shift
    localparam int c_prod_width = ADDR_WIDTH + 8;

    logic [c_stage_width-1:0] w_k;
    logic [ADDR_WIDTH-1:0]    w_p_ext;
    logic [ADDR_WIDTH-1:0]    w_one;
    logic [ADDR_WIDTH-1:0]    w_low_mask;
    logic [ADDR_WIDTH-1:0]    w_high;

    // Split p at bit k and open a gap there for the pair-select bit
    always_comb begin
        w_k        = (int'(i_e) <= ADDR_WIDTH - 1)
                   ? c_stage_width'(ADDR_WIDTH - 1 - int'(i_e)) : '0;
        w_p_ext    = {1'b0, i_p};
        w_one      = ADDR_WIDTH'(1);
        w_low_mask = (w_one << w_k) - w_one;
        w_high     = (w_p_ext >> w_k) << ({1'b0, w_k} + 4'd1);
        o_addr_a   = w_high | (w_p_ext & w_low_mask);
        o_addr_b   = o_addr_a | (w_one << w_k);
        o_tw_addr  = TW_WIDTH'((c_prod_width'(1) << i_e)
                   + ((c_prod_width'(i_p) << i_e) >> (ADDR_WIDTH - 1)));
    end

endmodule
`default_nettype wire

// File: rtl/ntt_stage_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_stage_scheduler
//  Description : Issues butterfly read pairs stage by stage, mirrors them to
//                write-back strobes after the butterfly latency, and waits
//                for each stage's last write to settle before the next stage
//                reads it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_stage_scheduler
    import ntt_pkg::*;
#(
    parameter int ADDR_WIDTH      = c_addr_width,
    parameter int BU_LATE         = c_bu_late,
    parameter int WRITE_BACK_LATE = c_write_back_late,
    parameter int NUM_STAGES      = c_num_stages,
    parameter int TW_WIDTH        = c_tw_width
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    ntt_stage_scheduler_if.slave    bus
);
    localparam int c_pair_width   = ADDR_WIDTH - 1;
    localparam int c_last_pair    = (2 ** c_pair_width) - 1;
    // Cycles from the last issue until the next issue may be registered
    localparam int c_drain_cycles = BU_LATE + WRITE_BACK_LATE;
    localparam int c_drain_width  = $clog2(c_drain_cycles + 1);

    state_t                   r_state;
    logic [c_stage_width-1:0] r_s;
    logic [c_pair_width-1:0]  r_p;
    logic                     r_is_ntt;
    logic [c_drain_width-1:0] r_drain_cnt;

    logic                     r_rd_en;
    logic [ADDR_WIDTH-1:0]    r_rd_addr_a;
    logic [ADDR_WIDTH-1:0]    r_rd_addr_b;
    logic [TW_WIDTH-1:0]      r_tw_addr;
    logic [c_stage_width-1:0] r_stage;
    logic                     r_busy;
    logic                     r_done;

    logic                     r_dl_en [BU_LATE];
    logic [ADDR_WIDTH-1:0]    r_dl_a  [BU_LATE];
    logic [ADDR_WIDTH-1:0]    r_dl_b  [BU_LATE];

    logic [c_stage_width-1:0] w_e;
    logic [ADDR_WIDTH-1:0]    w_addr_a;
    logic [ADDR_WIDTH-1:0]    w_addr_b;
    logic [TW_WIDTH-1:0]      w_tw_addr;

    // Inverse transforms walk the stages in reverse order
    assign w_e = r_is_ntt ? r_s : (c_stage_width'(NUM_STAGES - 1) - r_s);

    ntt_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .TW_WIDTH   (TW_WIDTH)
    ) u_addr_gen (
        .i_p       (r_p),
        .i_e       (w_e),
        .o_addr_a  (w_addr_a),
        .o_addr_b  (w_addr_b),
        .o_tw_addr (w_tw_addr)
    );

    // Stage/pair sequencing with registered issue strobes and status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_p         <= '0;
            r_is_ntt    <= 1'b0;
            r_drain_cnt <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_addr   <= '0;
            r_stage     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_state  <= ST_ISSUE;
                        r_is_ntt <= bus.is_ntt_i;
                        r_s      <= '0;
                        r_p      <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.hold_i) begin
                        r_rd_en     <= 1'b1;
                        r_rd_addr_a <= w_addr_a;
                        r_rd_addr_b <= w_addr_b;
                        r_tw_addr   <= w_tw_addr;
                        r_stage     <= w_e;
                        r_p         <= r_p + c_pair_width'(1);
                        if (r_p == c_pair_width'(c_last_pair)) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= c_drain_width'(c_drain_cycles - 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        if (r_s == c_stage_width'(NUM_STAGES - 1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_s     <= r_s + c_stage_width'(1);
                            r_state <= ST_ISSUE;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_drain_width'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Butterfly latency mirror: runs freely so hold never stalls write-back
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BU_LATE; i++) begin
                r_dl_en[i] <= 1'b0;
                r_dl_a[i]  <= '0;
                r_dl_b[i]  <= '0;
            end
        end else begin
            r_dl_en[0] <= r_rd_en;
            r_dl_a[0]  <= r_rd_addr_a;
            r_dl_b[0]  <= r_rd_addr_b;
            for (int i = 1; i < BU_LATE; i++) begin
                r_dl_en[i] <= r_dl_en[i-1];
                r_dl_a[i]  <= r_dl_a[i-1];
                r_dl_b[i]  <= r_dl_b[i-1];
            end
        end
    end

    assign bus.rd_en_o     = r_rd_en;
    assign bus.rd_addr_a_o = r_rd_addr_a;
    assign bus.rd_addr_b_o = r_rd_addr_b;
    assign bus.tw_addr_o   = r_tw_addr;
    assign bus.stage_o     = r_stage;
    assign bus.wr_en_o     = r_dl_en[BU_LATE-1];
    assign bus.wr_addr_a_o = r_dl_a[BU_LATE-1];
    assign bus.wr_addr_b_o = r_dl_b[BU_LATE-1];
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_stage_scheduler
//  Description : Directed self-checking bench for ntt_stage_scheduler with a
//                cycle-level model of issue/write-back timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_stage_scheduler;

    localparam int c_bu     = 7;
    localparam int c_period = 16 + 7 + 2;
    localparam int c_done   = 176;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ntt_stage_scheduler_if #(.ADDR_WIDTH(5), .TW_WIDTH(7)) bus ();

    ntt_stage_scheduler #(
        .ADDR_WIDTH      (5),
        .BU_LATE         (7),
        .WRITE_BACK_LATE (2),
        .NUM_STAGES      (7),
        .TW_WIDTH        (7)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observations gathered by one run
    int rd_bad, wr_bad, busy_bad, done_bad;
    int rd_cnt, wr_cnt, done_cnt, done_n;
    int f_stage, f_a, f_b, f_tw, last_stage;
    int first_rd_s1, last_wr_s0;
    int hold_rd, hold_wr, wr_after_rst;
    longint post_rst;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected issue at sample n: returns 1 and the (s, p) being issued
    function automatic bit exp_issue(input int n, input int hold_at,
                                     output int s, output int p);
        int m, q, r;
        s = 0;
        p = 0;
        m = n;
        if (hold_at >= 0) begin
            if (n >= hold_at && n < hold_at + 5) return 1'b0;
            if (n >= hold_at + 5) m = n - 5;
        end
        if (m < 1) return 1'b0;
        q = (m - 1) / c_period;
        r = (m - 1) % c_period;
        if (q >= 7 || r >= 16) return 1'b0;
        s = q;
        p = r;
        return 1'b1;
    endfunction

    function automatic void model_addr(input int p, input int e,
                                       output int a, output int b, output int tw);
        int k, j;
        k = (e <= 4) ? 4 - e : 0;
        a = 0;
        j = 0;
        for (int i = 0; i < 5; i++) begin
            if (i != k) begin
                a = a | (((p >> j) & 1) << i);
                j++;
            end
        end
        b  = a | (1 << k);
        tw = ((1 << e) + ((p << e) >> 4)) & 127;
    endfunction

    task automatic run(input bit ntt, input int hold_at, input int rst_at,
                       input int restart_at, input int n_samples);
        rd_bad = 0; wr_bad = 0; busy_bad = 0; done_bad = 0;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_n = -1;
        f_stage = -1; f_a = -1; f_b = -1; f_tw = -1; last_stage = -1;
        first_rd_s1 = -1; last_wr_s0 = -1;
        hold_rd = 0; hold_wr = 0; wr_after_rst = 0; post_rst = -1;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.is_ntt_i = ntt;
        @(negedge clk);
        bus.start_i  = 1'b0;
        bus.is_ntt_i = ~ntt;
        for (int n = 0; n < n_samples; n++) begin
            bit aborted, er, ew, in_hold;
            int s, p, e, a, b, tw, dexp;
            aborted = (rst_at >= 0 && n > rst_at);
            in_hold = (hold_at >= 0 && n >= hold_at && n < hold_at + 5);
            // read side
            er = aborted ? 1'b0 : exp_issue(n, hold_at, s, p);
            if (bus.rd_en_o !== er) rd_bad++;
            else if (er) begin
                e = ntt ? s : 6 - s;
                model_addr(p, e, a, b, tw);
                if (int'(bus.stage_o) != e || int'(bus.rd_addr_a_o) != a ||
                    int'(bus.rd_addr_b_o) != b || int'(bus.tw_addr_o) != tw)
                    rd_bad++;
            end
            if (bus.rd_en_o === 1'b1) begin
                rd_cnt++;
                if (f_stage < 0) begin
                    f_stage = int'(bus.stage_o);
                    f_a     = int'(bus.rd_addr_a_o);
                    f_b     = int'(bus.rd_addr_b_o);
                    f_tw    = int'(bus.tw_addr_o);
                end
                last_stage = int'(bus.stage_o);
                if (int'(bus.stage_o) == (ntt ? 1 : 5) && first_rd_s1 < 0)
                    first_rd_s1 = n;
                if (in_hold) hold_rd++;
            end
            // write-back side
            ew = aborted ? 1'b0 : exp_issue(n - c_bu, hold_at, s, p);
            if (bus.wr_en_o !== ew) wr_bad++;
            else if (ew) begin
                e = ntt ? s : 6 - s;
                model_addr(p, e, a, b, tw);
                if (int'(bus.wr_addr_a_o) != a || int'(bus.wr_addr_b_o) != b)
                    wr_bad++;
            end
            if (bus.wr_en_o === 1'b1) begin
                wr_cnt++;
                if (first_rd_s1 < 0) last_wr_s0 = n;
                if (aborted) wr_after_rst++;
                if (in_hold) hold_wr++;
            end
            // status
            dexp = aborted ? -1 : c_done + ((hold_at >= 0) ? 5 : 0);
            if (bus.done_o !== (n == dexp)) done_bad++;
            if (bus.done_o === 1'b1) begin
                done_cnt++;
                done_n = n;
            end
            if (bus.busy_o !== (!aborted && n <= dexp - 2)) busy_bad++;
            if (rst_at >= 0 && n == rst_at + 1)
                post_rst = longint'({bus.rd_en_o, bus.wr_en_o, bus.busy_o, bus.done_o,
                                     bus.stage_o, bus.tw_addr_o, bus.rd_addr_a_o,
                                     bus.rd_addr_b_o, bus.wr_addr_a_o, bus.wr_addr_b_o});
            // inputs for the next edge
            rst         = (n == rst_at);
            bus.hold_i  = (hold_at >= 0 && n + 1 >= hold_at && n + 1 < hold_at + 5);
            bus.start_i = (n + 1 == restart_at);
            @(negedge clk);
        end
        rst         = 1'b0;
        bus.hold_i  = 1'b0;
        bus.start_i = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.is_ntt_i = 1'b0;
        bus.hold_i   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              longint'({bus.rd_en_o, bus.wr_en_o, bus.busy_o, bus.done_o,
                        bus.stage_o, bus.tw_addr_o, bus.rd_addr_a_o,
                        bus.rd_addr_b_o, bus.wr_addr_a_o, bus.wr_addr_b_o}), 0);
        rst = 1'b0;
        @(negedge clk);

        // forward transform, no hold
        run(1'b1, -1, -1, -1, 200);
        check("fwd_first_stage", f_stage, 0);
        check("fwd_first_addr_a", f_a, 0);
        check("fwd_first_addr_b", f_b, 16);
        check("fwd_first_tw", f_tw, 1);
        check("fwd_rd_seq", rd_bad, 0);
        check("fwd_wr_seq", wr_bad, 0);
        check("fwd_busy", busy_bad, 0);
        check("fwd_done_seq", done_bad, 0);
        check("fwd_done_cycle", done_n, 176);
        check("fwd_done_count", done_cnt, 1);
        check("fwd_rd_count", rd_cnt, 112);
        check("fwd_wr_count", wr_cnt, 112);
        check("stage_gap", first_rd_s1 - last_wr_s0, 3);

        // inverse transform
        run(1'b0, -1, -1, -1, 200);
        check("inv_first_stage", f_stage, 6);
        check("inv_first_addr_a", f_a, 0);
        check("inv_first_addr_b", f_b, 1);
        check("inv_first_tw", f_tw, 64);
        check("inv_last_stage", last_stage, 0);
        check("inv_rd_seq", rd_bad, 0);
        check("inv_wr_seq", wr_bad, 0);
        check("inv_done_cycle", done_n, 176);

        // hold for 5 cycles inside stage 0
        run(1'b1, 5, -1, -1, 200);
        check("hold_rd_in_window", hold_rd, 0);
        check("hold_wr_in_window", hold_wr, 2);
        check("hold_rd_seq", rd_bad, 0);
        check("hold_wr_seq", wr_bad, 0);
        check("hold_busy", busy_bad, 0);
        check("hold_done_cycle", done_n, 181);
        check("hold_done_count", done_cnt, 1);

        // reset at cycle 40, then a clean transform
        run(1'b1, -1, 40, -1, 200);
        check("abort_post_reset", post_rst, 0);
        check("abort_wr_after", wr_after_rst, 0);
        check("abort_done_count", done_cnt, 0);
        check("abort_rd_seq", rd_bad, 0);
        check("abort_busy", busy_bad, 0);
        run(1'b1, -1, -1, -1, 200);
        check("restart_done_cycle", done_n, 176);
        check("restart_done_count", done_cnt, 1);
        check("restart_rd_seq", rd_bad, 0);
        check("restart_wr_seq", wr_bad, 0);

        // start pulsed while busy
        run(1'b1, -1, -1, 50, 260);
        check("busy_start_done_count", done_cnt, 1);
        check("busy_start_done_cycle", done_n, 176);
        check("busy_start_rd_seq", rd_bad, 0);
        check("busy_start_busy", busy_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
